// File: rtl/accelerator_retention_vector.sv
`default_nettype none
// ============================================================================
// Module      : accelerator_retention_vector
// Description : DNC memory retention vector
//                 psi(j) = prod_i (1 - f(i) * w_r(i,j))
//               Unsigned fixed point with FRACT_SIZE fraction bits.
//               Input pairs (f, w) arrive with j as the outer loop and i as
//               the inner loop; one psi value is streamed out per column j.
// Ports       : CLK            clock, rising edge
//               RST            asynchronous active-low reset
//               START          begins a computation when idle
//               READY          one-cycle pulse once all N psi are emitted
//               IN_READY       block can accept an (F_IN, W_IN) pair
//               IN_ENABLE      qualifies F_IN / W_IN
//               SIZE_R_IN      R, number of read heads (sampled at START)
//               SIZE_N_IN      N, number of memory locations (at START)
//               F_IN           free gate f(t;i)
//               W_IN           read weighting w_r(t-1;i,j)
//               PSI_OUT        psi(t;j), held between strobes
//               PSI_OUT_ENABLE one-cycle strobe marking PSI_OUT valid
//               PSI_INDEX_OUT  j of the current PSI_OUT
// Revision    : 1.0 - initial release
// ============================================================================
module accelerator_retention_vector #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FRACT_SIZE   = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  output logic                    IN_READY,
  input  logic                    IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    SIZE_R_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_N_IN,
  input  logic [DATA_SIZE-1:0]    F_IN,
  input  logic [DATA_SIZE-1:0]    W_IN,
  output logic [DATA_SIZE-1:0]    PSI_OUT,
  output logic                    PSI_OUT_ENABLE,
  output logic [CONTROL_SIZE-1:0] PSI_INDEX_OUT
);

  localparam logic [DATA_SIZE-1:0]    c_one   = DATA_SIZE'(1) << FRACT_SIZE;
  localparam logic [DATA_SIZE-1:0]    c_d_one = DATA_SIZE'(1);
  localparam logic [CONTROL_SIZE-1:0] c_c_one = CONTROL_SIZE'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INPUT   = 3'd1,
    ST_PRODUCT = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [DATA_SIZE-1:0]    r_size_r;
  logic [DATA_SIZE-1:0]    r_size_n;
  logic [CONTROL_SIZE-1:0] r_i;
  logic [CONTROL_SIZE-1:0] r_j;
  logic [DATA_SIZE-1:0]    r_f;
  logic [DATA_SIZE-1:0]    r_w;
  logic [DATA_SIZE-1:0]    r_t;
  logic [DATA_SIZE-1:0]    r_acc;
  logic [DATA_SIZE-1:0]    r_psi;
  logic [CONTROL_SIZE-1:0] r_psi_idx;
  logic                    r_psi_en;
  logic                    r_ready;

  logic [DATA_SIZE-1:0]    w_f_sat;
  logic [DATA_SIZE-1:0]    w_w_sat;
  logic [DATA_SIZE-1:0]    w_t;
  logic [DATA_SIZE-1:0]    w_acc_next;
  logic                    w_last_i;
  logic                    w_last_j;
  logic                    w_zero_size;

  // Inputs above ONE are clamped so that f*w never exceeds ONE and the
  // (ONE - t) factor cannot underflow.
  assign w_f_sat = (F_IN > c_one) ? c_one : F_IN;
  assign w_w_sat = (W_IN > c_one) ? c_one : W_IN;

  // Full double-width products, then drop the fraction bits (truncation).
  assign w_t        = DATA_SIZE'(({{DATA_SIZE{1'b0}}, r_f} *
                                  {{DATA_SIZE{1'b0}}, r_w}) >> FRACT_SIZE);
  assign w_acc_next = DATA_SIZE'(({{DATA_SIZE{1'b0}}, r_acc} *
                                  {{DATA_SIZE{1'b0}}, (c_one - r_t)}) >> FRACT_SIZE);

  assign w_last_i    = (DATA_SIZE'(r_i) == (r_size_r - c_d_one));
  assign w_last_j    = (DATA_SIZE'(r_j) == (r_size_n - c_d_one));
  assign w_zero_size = (SIZE_R_IN == '0) || (SIZE_N_IN == '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_next_state = w_zero_size ? ST_FINISH : ST_INPUT;
        end
      end
      ST_INPUT: begin
        if (IN_ENABLE) begin
          w_next_state = ST_PRODUCT;
        end
      end
      ST_PRODUCT: begin
        w_next_state = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (!w_last_i || !w_last_j) begin
          w_next_state = ST_INPUT;
        end else begin
          w_next_state = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath, counters and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_size_r  <= '0;
      r_size_n  <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_f       <= '0;
      r_w       <= '0;
      r_t       <= '0;
      r_acc     <= '0;
      r_psi     <= '0;
      r_psi_idx <= '0;
      r_psi_en  <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_psi_en <= 1'b0;
      r_ready  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_size_r <= SIZE_R_IN;
            r_size_n <= SIZE_N_IN;
            r_i      <= '0;
            r_j      <= '0;
            r_acc    <= c_one;
          end
        end
        ST_INPUT: begin
          if (IN_ENABLE) begin
            r_f <= w_f_sat;
            r_w <= w_w_sat;
          end
        end
        ST_PRODUCT: begin
          r_t <= w_t;
        end
        ST_ACCUM: begin
          if (!w_last_i) begin
            r_acc <= w_acc_next;
            r_i   <= r_i + c_c_one;
          end else begin
            // Column complete: publish psi(j) and rearm the product.
            r_psi     <= w_acc_next;
            r_psi_idx <= r_j;
            r_psi_en  <= 1'b1;
            r_acc     <= c_one;
            r_i       <= '0;
            if (!w_last_j) begin
              r_j <= r_j + c_c_one;
            end
          end
        end
        ST_FINISH: begin
          // READY is registered, so it lands one cycle after the last strobe.
          r_ready <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign IN_READY       = (r_state == ST_INPUT);
  assign READY          = r_ready;
  assign PSI_OUT        = r_psi;
  assign PSI_OUT_ENABLE = r_psi_en;
  assign PSI_INDEX_OUT  = r_psi_idx;

endmodule
`default_nettype wire

// File: tb/tb_accelerator_retention_vector.sv
`default_nettype none
// ============================================================================
// Module      : tb_accelerator_retention_vector
// Description : Self-checking bench for accelerator_retention_vector. Psi
//               values are predicted by a fixed-point product model over
//               stored (f, w) tables; timing of strobes, READY and input
//               acceptance is checked against edge counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accelerator_retention_vector;

  localparam logic [63:0] ONE     = 64'h1_0000_0000;
  localparam logic [63:0] HALF    = 64'h0_8000_0000;
  localparam logic [63:0] QUARTER = 64'h0_4000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        IN_ENABLE = 1'b0;
  logic [63:0] SIZE_R_IN = '0;
  logic [63:0] SIZE_N_IN = '0;
  logic [63:0] F_IN = '0;
  logic [63:0] W_IN = '0;
  logic        READY;
  logic        IN_READY;
  logic [63:0] PSI_OUT;
  logic        PSI_OUT_ENABLE;
  logic [63:0] PSI_INDEX_OUT;

  accelerator_retention_vector dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .READY          (READY),
    .IN_READY       (IN_READY),
    .IN_ENABLE      (IN_ENABLE),
    .SIZE_R_IN      (SIZE_R_IN),
    .SIZE_N_IN      (SIZE_N_IN),
    .F_IN           (F_IN),
    .W_IN           (W_IN),
    .PSI_OUT        (PSI_OUT),
    .PSI_OUT_ENABLE (PSI_OUT_ENABLE),
    .PSI_INDEX_OUT  (PSI_INDEX_OUT)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  // Edge counter and output monitor (monitor only appends; tests diff).
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [63:0] psi_q[$];
  logic [63:0] idx_q[$];
  int ready_cnt = 0;
  int ready_cyc = -1;
  int last_strobe_cyc = -1;
  int in_ready_cnt = 0;

  always @(negedge CLK) begin
    if (PSI_OUT_ENABLE === 1'b1) begin
      psi_q.push_back(PSI_OUT);
      idx_q.push_back(PSI_INDEX_OUT);
      last_strobe_cyc = cyc;
    end
    if (READY === 1'b1) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
    if (IN_READY === 1'b1) in_ready_cnt++;
  end

  // Stimulus tables: g_f[j][i], g_w[j][i]
  logic [63:0] g_f[8][8];
  logic [63:0] g_w[8][8];
  int start_cyc = 0;
  int ready_base = 0;
  int feed_to = 0;

  // Reference: straight product over i of (1 - f*w), each step truncated.
  function automatic logic [63:0] model_psi(int r, int j);
    logic [127:0] acc, f, w, t;
    acc = 128'(ONE);
    for (int i = 0; i < r; i++) begin
      f   = (g_f[j][i] > ONE) ? 128'(ONE) : 128'(g_f[j][i]);
      w   = (g_w[j][i] > ONE) ? 128'(ONE) : 128'(g_w[j][i]);
      t   = (f * w) >> 32;
      acc = (acc * (128'(ONE) - t)) >> 32;
    end
    return acc[63:0];
  endfunction

  function automatic logic [63:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 64'h0;
      1:       return ONE;
      2:       return {30'h0, 2'($urandom_range(1, 3)), 32'($urandom())};
      default: return {32'h0, 32'($urandom())};
    endcase
  endfunction

  task automatic pulse_start(input logic [63:0] r, input logic [63:0] n);
    @(negedge CLK);
    ready_base = ready_cnt;
    SIZE_R_IN = r;
    SIZE_N_IN = n;
    START = 1'b1;
    @(posedge CLK);
    #1;
    start_cyc = cyc;
    START = 1'b0;
    // Sizes must be ignored once started.
    SIZE_R_IN = {32'h0, 32'($urandom())};
    SIZE_N_IN = {32'h0, 32'($urandom())};
  endtask

  task automatic feed_pair(input logic [63:0] f, input logic [63:0] w);
    bit ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (IN_READY === 1'b1) begin
        F_IN = f;
        W_IN = w;
        IN_ENABLE = 1'b1;
        @(posedge CLK);
        #1;
        IN_ENABLE = 1'b0;
        F_IN = {32'($urandom()), 32'($urandom())};
        W_IN = {32'($urandom()), 32'($urandom())};
        ok = 1;
        break;
      end
    end
    if (!ok) feed_to++;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      #1;
      if (ready_cnt != ready_base) break;
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic run_job(input int r, input int n);
    pulse_start(64'(r), 64'(n));
    for (int j = 0; j < n; j++)
      for (int i = 0; i < r; i++)
        feed_pair(g_f[j][i], g_w[j][i]);
    wait_ready();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    #3 RST = 1'b0;
    #1;
    n_total++; if (PSI_OUT !== 64'h0) begin n_bad++; $display("FAIL reset_psi got=%h exp=0", PSI_OUT); end
    n_total++; if (PSI_OUT_ENABLE !== 1'b0) begin n_bad++; $display("FAIL reset_psi_en got=%b exp=0", PSI_OUT_ENABLE); end
    n_total++; if (PSI_INDEX_OUT !== 64'h0) begin n_bad++; $display("FAIL reset_idx got=%h exp=0", PSI_INDEX_OUT); end
    n_total++; if (READY !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", READY); end
    n_total++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", IN_READY); end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_total++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL idle_in_ready got=%b exp=0", IN_READY); end
  endtask

  task automatic test_directed();
    int r, n, pb, rb, cnt;
    logic [63:0] exp_psi[2];
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin r = 1; n = 1; g_f[0][0] = ONE; g_w[0][0] = ONE; exp_psi[0] = 64'h0; end
        1: begin r = 1; n = 1; g_f[0][0] = HALF; g_w[0][0] = HALF; exp_psi[0] = 64'hC000_0000; end
        2: begin
          r = 2; n = 2;
          g_f[0][0] = HALF; g_w[0][0] = HALF;
          g_f[0][1] = HALF; g_w[0][1] = HALF;
          g_f[1][0] = HALF; g_w[1][0] = 64'h0;
          g_f[1][1] = ONE;  g_w[1][1] = QUARTER;
          exp_psi[0] = 64'h9000_0000; exp_psi[1] = 64'hC000_0000;
        end
        default: begin r = 1; n = 1; g_f[0][0] = 64'h2_0000_0000; g_w[0][0] = ONE; exp_psi[0] = 64'h0; end
      endcase
      pb = psi_q.size();
      rb = ready_cnt;
      run_job(r, n);
      cnt = psi_q.size() - pb;
      n_total++; if (cnt !== n) begin n_bad++; $display("FAIL dir%0d_strobes got=%0d exp=%0d", c, cnt, n); end
      for (int j = 0; j < n; j++) begin
        n_total++;
        if (pb + j >= psi_q.size()) begin
          n_bad++; $display("FAIL dir%0d_psi%0d got=none exp=%h", c, j, exp_psi[j]);
        end else begin
          if (psi_q[pb+j] !== exp_psi[j]) begin n_bad++; $display("FAIL dir%0d_psi%0d got=%h exp=%h", c, j, psi_q[pb+j], exp_psi[j]); end
          n_total++;
          if (idx_q[pb+j] !== 64'(j)) begin n_bad++; $display("FAIL dir%0d_idx%0d got=%0d exp=%0d", c, j, idx_q[pb+j], j); end
        end
      end
      n_total++; if (ready_cnt - rb !== 1) begin n_bad++; $display("FAIL dir%0d_ready_cnt got=%0d exp=1", c, ready_cnt - rb); end
      n_total++; if (ready_cyc !== last_strobe_cyc + 1) begin n_bad++; $display("FAIL dir%0d_ready_time got=%0d exp=%0d", c, ready_cyc, last_strobe_cyc + 1); end
    end
  endtask

  task automatic test_random();
    int r, n, pb, rb, cnt;
    logic [63:0] exp_v;
    for (int job = 0; job < 8; job++) begin
      r = $urandom_range(1, 4);
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++)
        for (int i = 0; i < r; i++) begin
          g_f[j][i] = rnd_word();
          g_w[j][i] = rnd_word();
        end
      pb = psi_q.size();
      rb = ready_cnt;
      run_job(r, n);
      cnt = psi_q.size() - pb;
      n_total++; if (cnt !== n) begin n_bad++; $display("FAIL rnd%0d_strobes got=%0d exp=%0d", job, cnt, n); end
      for (int j = 0; j < n && pb + j < psi_q.size(); j++) begin
        exp_v = model_psi(r, j);
        n_total++; if (psi_q[pb+j] !== exp_v) begin n_bad++; $display("FAIL rnd%0d_psi%0d got=%h exp=%h", job, j, psi_q[pb+j], exp_v); end
        n_total++; if (idx_q[pb+j] !== 64'(j)) begin n_bad++; $display("FAIL rnd%0d_idx%0d got=%0d exp=%0d", job, j, idx_q[pb+j], j); end
      end
      n_total++; if (ready_cnt - rb !== 1) begin n_bad++; $display("FAIL rnd%0d_ready_cnt got=%0d exp=1", job, ready_cnt - rb); end
    end
    n_total++; if (feed_to !== 0) begin n_bad++; $display("FAIL feed_timeouts got=%0d exp=0", feed_to); end
  endtask

  task automatic test_zero_size();
    int pb, rb, ib;
    for (int c = 0; c < 2; c++) begin
      pb = psi_q.size();
      rb = ready_cnt;
      ib = in_ready_cnt;
      if (c == 0) pulse_start(64'd0, 64'd4);
      else        pulse_start(64'd3, 64'd0);
      wait_ready();
      n_total++; if (psi_q.size() - pb !== 0) begin n_bad++; $display("FAIL zero%0d_strobes got=%0d exp=0", c, psi_q.size() - pb); end
      n_total++; if (ready_cnt - rb !== 1) begin n_bad++; $display("FAIL zero%0d_ready_cnt got=%0d exp=1", c, ready_cnt - rb); end
      n_total++; if (ready_cyc !== start_cyc + 1) begin n_bad++; $display("FAIL zero%0d_ready_time got=%0d exp=%0d", c, ready_cyc, start_cyc + 1); end
      n_total++; if (in_ready_cnt - ib !== 0) begin n_bad++; $display("FAIL zero%0d_in_ready got=%0d exp=0", c, in_ready_cnt - ib); end
    end
  endtask

  // IN_ENABLE held high throughout, a START pulse mid-run, sizes changed.
  task automatic test_back_to_back();
    int pb, rb, k;
    int acc_cyc[4];
    bit started;
    logic [63:0] exp_v;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 2; i++) begin
        g_f[j][i] = rnd_word();
        g_w[j][i] = rnd_word();
      end
    pb = psi_q.size();
    rb = ready_cnt;
    pulse_start(64'd2, 64'd2);
    IN_ENABLE = 1'b1;
    k = 0;
    started = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge CLK);
      START = 1'b0;
      if (k == 2 && !started) begin
        START = 1'b1;
        SIZE_R_IN = 64'd5;
        SIZE_N_IN = 64'd7;
        started = 1;
      end
      if (IN_READY === 1'b1 && k < 4) begin
        F_IN = g_f[k/2][k%2];
        W_IN = g_w[k/2][k%2];
        acc_cyc[k] = cyc + 1;
        k++;
      end else begin
        F_IN = {32'($urandom()), 32'($urandom())};
        W_IN = {32'($urandom()), 32'($urandom())};
      end
      #1;
      if (ready_cnt != ready_base) break;
    end
    IN_ENABLE = 1'b0;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    n_total++; if (k !== 4) begin n_bad++; $display("FAIL b2b_pairs got=%0d exp=4", k); end
    for (int m = 1; m < 4 && m < k; m++) begin
      n_total++;
      if (acc_cyc[m] - acc_cyc[m-1] !== 3) begin n_bad++; $display("FAIL b2b_spacing%0d got=%0d exp=3", m, acc_cyc[m] - acc_cyc[m-1]); end
    end
    n_total++; if (psi_q.size() - pb !== 2) begin n_bad++; $display("FAIL b2b_strobes got=%0d exp=2", psi_q.size() - pb); end
    for (int j = 0; j < 2 && pb + j < psi_q.size(); j++) begin
      exp_v = model_psi(2, j);
      n_total++; if (psi_q[pb+j] !== exp_v) begin n_bad++; $display("FAIL b2b_psi%0d got=%h exp=%h", j, psi_q[pb+j], exp_v); end
    end
    n_total++; if (ready_cnt - rb !== 1) begin n_bad++; $display("FAIL b2b_ready_cnt got=%0d exp=1", ready_cnt - rb); end
  endtask

  task automatic test_reset_mid();
    int pb, rb;
    logic [63:0] exp_v;
    g_f[0][0] = HALF; g_w[0][0] = HALF;
    g_f[1][0] = HALF; g_w[1][0] = HALF;
    pb = psi_q.size();
    rb = ready_cnt;
    pulse_start(64'd1, 64'd2);
    feed_pair(g_f[0][0], g_w[0][0]);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      #1;
      if (psi_q.size() != pb) break;
    end
    n_total++; if (PSI_OUT !== 64'hC000_0000) begin n_bad++; $display("FAIL mid_first_psi got=%h exp=c0000000", PSI_OUT); end
    RST = 1'b0;
    #1;
    n_total++; if (PSI_OUT !== 64'h0) begin n_bad++; $display("FAIL mid_rst_psi got=%h exp=0", PSI_OUT); end
    n_total++; if (PSI_OUT_ENABLE !== 1'b0) begin n_bad++; $display("FAIL mid_rst_psi_en got=%b exp=0", PSI_OUT_ENABLE); end
    n_total++; if (PSI_INDEX_OUT !== 64'h0) begin n_bad++; $display("FAIL mid_rst_idx got=%h exp=0", PSI_INDEX_OUT); end
    n_total++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL mid_rst_in_ready got=%b exp=0", IN_READY); end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    #1;
    n_total++; if (ready_cnt - rb !== 0) begin n_bad++; $display("FAIL mid_no_ready got=%0d exp=0", ready_cnt - rb); end
    n_total++; if (psi_q.size() - pb !== 1) begin n_bad++; $display("FAIL mid_strobes got=%0d exp=1", psi_q.size() - pb); end
    // Fresh run after the abort.
    g_f[0][0] = rnd_word(); g_w[0][0] = rnd_word();
    g_f[0][1] = rnd_word(); g_w[0][1] = rnd_word();
    pb = psi_q.size();
    rb = ready_cnt;
    run_job(2, 1);
    exp_v = model_psi(2, 0);
    n_total++;
    if (psi_q.size() - pb !== 1) begin
      n_bad++; $display("FAIL post_rst_strobes got=%0d exp=1", psi_q.size() - pb);
    end else if (psi_q[pb] !== exp_v) begin
      n_bad++; $display("FAIL post_rst_psi got=%h exp=%h", psi_q[pb], exp_v);
    end
    n_total++; if (ready_cnt - rb !== 1) begin n_bad++; $display("FAIL post_rst_ready got=%0d exp=1", ready_cnt - rb); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_zero_size();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
